bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared tri-state system bus (address, data, r_w) used by several master devices.
- Each master raises request, waits for grant, drives the bus while granted, and drops or advances its request after the slave pulses ready.
- Grants exactly one master at a time and holds that grant for the whole transfer.
- Inserts one idle turnaround cycle between owners so tri-state drivers never overlap.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- IDX_W, $clog2(N_MASTERS), width of the owner index.
- TIMEOUT_CYCLES, 255, cycles a granted transfer may wait for ready (used only with BUS_TIMEOUT_EN).

Ports:
- clk  input  1  bus clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- request  input  N_MASTERS  per-master request; bit i belongs to master i.
- ready  input  1  slave transfer-complete strobe, one cycle.
- grant  output  N_MASTERS  one-hot grant; all zero when the bus is idle.
- owner  output  IDX_W  index of the granted master; valid only while bus_busy=1.
- bus_busy  output  1  high while any grant bit is high.
- timeout_err  output  1  one-cycle pulse on transfer timeout (BUS_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, grant=0, owner=0, bus_busy=0, timeout_err=0, priority pointer ptr=0.
- All outputs are registered. There is no combinational path from request or ready to grant.
- IDLE state:
  - If request==0, stay in IDLE.
  - Otherwise select the first set request bit at or after ptr, searching circularly (i = ptr, ptr+1, ... wrapping from N_MASTERS-1 to 0).
  - At that edge: grant[sel]=1, owner=sel, go to OWN.
  - Latency: request first sampled high at edge k gives grant visible after edge k.
- OWN state:
  - grant stays constant while the state is OWN.
  - If ready=1 at an edge: grant=0, ptr=(owner+1) mod N_MASTERS, go to TURN. Any request[owner] value is ignored at this edge.
  - Else if request[owner]=0 (master abandoned the request): grant=0, ptr=owner+1, go to TURN.
  - If ready and the request drop occur on the same edge, treat it as completion. The result is identical either way.
- TURN state:
  - Exactly one cycle with grant=0, then go to IDLE unconditionally.
  - Back-to-back transfers therefore cost 1 cycle OWN minimum plus 1 TURN plus 1 IDLE arbitration edge.
- Fairness:
  - Requests held continuously are served strictly in rotation.
  - Worst-case wait is (N_MASTERS-1) transfers.
- ready seen while in IDLE or TURN: ignore it; no state change.
- ptr wrap-around: ptr=N_MASTERS-1 plus 1 gives 0. Index arithmetic is modulo N_MASTERS, which need not be a power of 2.
- Reset asserted mid-transfer: grant drops immediately (asynchronous). The master's in-flight transfer is lost, and the master must re-request.
- Invariant: at most one grant bit is set, and bus_busy equals the OR of grant.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - Add a cycle counter, cleared on entry to OWN and incremented each OWN cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES: grant=0, timeout_err pulses 1 for exactly one cycle, ptr=owner+1, go to TURN.
  - ready on the same edge as the timeout wins: completion, no error.
- Without the macro: no counter is generated, timeout_err is constant 0, and OWN waits indefinitely.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding constants ST_IDLE, ST_OWN, ST_TURN (2-bit);
  - default N_MASTERS;
  - the bus width constant BUS_W=32, for reuse by masters and slaves.
- One sub-module is natural: rr_select. It is combinational, takes request and ptr, and returns a found flag and the selected index using a circular priority search.

Test Plan:
- Single master: request=4'b0001 held, ready pulsed 3 cycles after grant -> grant=0001 the cycle after request; grant=0000 after the ready edge, one TURN cycle, then re-grant 0001 two edges later.
- All requesting: request=4'b1111 held, ready one cycle into each OWN -> grant sequence 0001,0010,0100,1000,0001 with a zero cycle between each; owner follows 0,1,2,3,0.
- Abandon: grant to master 2, master drops request[2] before ready -> grant=0 next edge; next grant goes to master 3 if requesting, else wraps to 0.
- Async reset mid-OWN: rst_n low between edges -> grant=0 and bus_busy=0 immediately; after release with request=0010 -> grant=0010 on the first active edge.
- Stray ready: ready pulsed while IDLE with request=0 -> no grant change; ptr unchanged, as shown by the next grant order.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8: grant master 1, no ready -> grant drops after 8 OWN cycles with a single-cycle timeout_err pulse. Repeat with ready on cycle 8 -> no timeout_err.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_pkg: definitions shared by the system-bus arbiter, its masters and its slaves.
//   state_t       - arbiter FSM state encoding (2-bit): ST_IDLE, ST_OWN, ST_TURN
//   DEF_N_MASTERS - default number of requesting masters
//   BUS_W         - width of the shared address/data bus
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam int unsigned DEF_N_MASTERS = 4;
  localparam int unsigned BUS_W         = 32;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// rr_select: combinational circular priority search.
// It returns the first set request bit at or after ptr, wrapping from N_MASTERS-1 to 0.
//   request [N_MASTERS-1:0] in  - per-master request vector
//   ptr     [IDX_W-1:0]     in  - index that has highest priority (must be < N_MASTERS)
//   found                   out - at least one request bit is set
//   sel     [IDX_W-1:0]     out - selected index; 0 when found=0
module rr_select
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = DEF_N_MASTERS,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] request,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     sel
);

  int unsigned idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      // The modulo is written as a subtraction so that N_MASTERS need not be a power of two.
      idx = 32'(ptr) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && request[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbiter for the shared tri-state system bus.
// One master owns the bus at a time. A one-cycle turnaround separates two owners.
// All outputs are registered.
//   clk         in  - bus clock
//   rst_n       in  - asynchronous active-low reset
//   request     in  - per-master request, bit i = master i
//   ready       in  - slave transfer-complete strobe
//   grant       out - one-hot grant; all zero while the bus is idle
//   owner       out - index of the granted master; valid while bus_busy=1
//   bus_busy    out - OR of grant
//   timeout_err out - one-cycle pulse on a transfer timeout
// Optional feature: define BUS_TIMEOUT_EN to abort a transfer when it waits
// TIMEOUT_CYCLES OWN cycles without ready. If it is undefined, timeout_err is tied to 0.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS      = DEF_N_MASTERS,
  parameter int unsigned IDX_W          = $clog2(N_MASTERS),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] request,
  input  logic                 ready,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]     owner,
  output logic                 bus_busy,
  output logic                 timeout_err
);

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_inc;
  logic                 found;
  logic [IDX_W-1:0]     sel;

  rr_select #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .request (request),
    .ptr     (ptr_q),
    .found   (found),
    .sel     (sel)
  );

  assign owner_inc = (owner_q == IDX_W'(N_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             to_hit;

  // cnt_q counts the OWN edges that have already passed without ready.
  // The edge that would make the count reach TIMEOUT_CYCLES is the timeout edge.
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_OWN;
          grant_d = N_MASTERS'(1) << sel;
          owner_d = sel;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_OWN: begin
        // ready takes precedence over a request drop and over a timeout.
        if (ready || !request[owner_q]) begin
          state_d = ST_TURN;
          grant_d = '0;
          ptr_d   = owner_inc;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_hit) begin
          state_d   = ST_TURN;
          grant_d   = '0;
          ptr_d     = owner_inc;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_err        = 1'b0;
`endif

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign bus_busy = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter (N_MASTERS=4, TIMEOUT_CYCLES=8).
// A transaction-level model tracks the owner, the turnaround gap and the rotation pointer.
// On every falling edge it is compared against the DUT outputs.
// Hand-computed literal checks pin the scenarios from the test plan.
// Define BUS_TIMEOUT_EN for both the bench and the RTL to exercise the timeout.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] request;
  logic         ready;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         bus_busy;
  logic         timeout_err;

  int total;
  int bad;

  bus_arbiter #(
    .N_MASTERS      (N),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .ready       (ready),
    .grant       (grant),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int m_owner;   // -1 when no master owns the bus
  int m_ptr;
  int m_wait;
  bit m_gap;     // turnaround cycle pending
  bit m_terr;

  initial begin
    bit done;
    int pick;
    int i;
    m_owner = -1; m_ptr = 0; m_wait = 0; m_gap = 0; m_terr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_wait = 0; m_gap = 0; m_terr = 0;
      end else begin
        m_terr = 0;
        if (m_gap) begin
          m_gap = 0;
        end else if (m_owner < 0) begin
          pick = -1;
          for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (pick < 0 && request[i]) pick = i;
          end
          if (pick >= 0) begin
            m_owner = pick;
            m_wait  = 0;
          end
        end else begin
          done = ready || !request[m_owner];
          if (!done) m_wait++;
`ifdef BUS_TIMEOUT_EN
          if (!done && m_wait >= TO) begin
            done   = 1;
            m_terr = 1;
          end
`endif
          if (done) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_gap   = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [N-1:0] exp_g;
    forever begin
      @(negedge clk);
      exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_grant", grant, exp_g);
      chk("model_busy", bus_busy, (m_owner >= 0));
      if (m_owner >= 0) chk("model_owner", owner, m_owner);
      chk("model_terr", timeout_err, m_terr);
      chk("onehot0", $onehot0(grant), 1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [N-1:0] req, input logic rdy);
    request = req;
    ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_grant", grant, 0);
    chk("rst_async_busy", bus_busy, 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; request = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_owner", owner, 0);
    chk("reset_busy", bus_busy, 0);
    chk("reset_terr", timeout_err, 0);
    rst_n = 1'b1;

    // Single master
    cyc(4'b0001, 0); chk("single_grant", grant, 4'b0001);
    cyc(4'b0001, 0);
    cyc(4'b0001, 0);
    cyc(4'b0001, 1); chk("single_ready_drop", grant, 0);
    cyc(4'b0001, 0); chk("single_turn_idle", grant, 0);
    cyc(4'b0001, 0); chk("single_regrant", grant, 4'b0001);
    cyc(4'b0000, 1); chk("single_done", grant, 0);
    cyc(4'b0000, 0);

    // Reset (ptr back to 0), stray ready in IDLE, then all masters requesting
    async_reset();
    cyc(4'b0000, 1); chk("stray_grant", grant, 0);
    cyc(4'b0000, 1); chk("stray_busy", bus_busy, 0);
    cyc(4'b0000, 0);
    for (int j = 0; j < 5; j++) begin
      cyc(4'b1111, 0);
      chk("rr_grant", grant, 4'b0001 << (j % 4));
      chk("rr_owner", owner, j % 4);
      cyc(4'b1111, 1); chk("rr_gap", grant, 0);
      cyc(4'b1111, 0); chk("rr_idle", grant, 0);
    end

    // Abandon: ptr=1, only master 2 requesting
    cyc(4'b0100, 0); chk("abandon_grant2", grant, 4'b0100);
    cyc(4'b0100, 0);
    cyc(4'b1001, 0); chk("abandon_drop", grant, 0);
    cyc(4'b1001, 0);
    cyc(4'b1001, 0); chk("abandon_next3", grant, 4'b1000);
    cyc(4'b1001, 1);
    cyc(4'b1000, 0);
    cyc(4'b1000, 0); chk("abandon_grant3", grant, 4'b1000);
    cyc(4'b0001, 0); chk("abandon3_drop", grant, 0);
    cyc(4'b0001, 0);
    cyc(4'b0001, 0); chk("abandon_wrap0", grant, 4'b0001);

    // Async reset while master 0 owns the bus
    cyc(4'b0001, 0);
    async_reset();
    cyc(4'b0010, 0);
    chk("post_reset_grant", grant, 4'b0010);
    chk("post_reset_owner", owner, 1);

    // ptr=2 after master 1 completes; request {1,0} must pick master 0
    cyc(4'b0000, 1);
    cyc(4'b0000, 0);
    cyc(4'b0011, 0); chk("ptr2_pick0", grant, 4'b0001);
    cyc(4'b0011, 1);
    cyc(4'b0000, 0);

    // Timeout behaviour (ptr=1)
    cyc(4'b0010, 0); chk("to_grant", grant, 4'b0010);
`ifdef BUS_TIMEOUT_EN
    for (int j = 0; j < TO - 1; j++) begin
      cyc(4'b0010, 0);
      chk("to_hold", grant, 4'b0010);
    end
    cyc(4'b0010, 0);
    chk("to_drop", grant, 0);
    chk("to_pulse", timeout_err, 1);
    cyc(4'b0010, 0); chk("to_pulse_end", timeout_err, 0);
    cyc(4'b0010, 0); chk("to_regrant", grant, 4'b0010);
    for (int j = 0; j < TO - 1; j++) cyc(4'b0010, 0);
    cyc(4'b0010, 1);
    chk("to_ready_drop", grant, 0);
    chk("to_ready_noerr", timeout_err, 0);
`else
    for (int j = 0; j < 20; j++) cyc(4'b0010, 0);
    chk("noto_hold", grant, 4'b0010);
    chk("noto_terr", timeout_err, 0);
    cyc(4'b0010, 1); chk("noto_done", grant, 0);
`endif
    cyc(4'b0000, 0);
    cyc(4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
